// File: rtl/mult_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_unit
//  Purpose  : Iterative ARM integer multiplier for the execute stage.
//             Supports MUL/MLA (32-bit result) and UMULL/UMLAL/SMULL/SMLAL
//             (64-bit result). The multiplier is consumed one byte per cycle
//             over 4 CALC iterations. A FIX cycle applies the sign and adds
//             the accumulate operand, then a single-cycle DONE state pulses
//             MultDoneE.
//  Ports    : clk        - pipeline clock, rising edge
//             reset      - asynchronous active-low reset
//             StartE     - multiply instruction present in execute
//             FlushE     - kill execute instruction / abort operation
//             MultOpE    - 000 MUL, 001 MLA, 100 UMULL, 101 UMLAL,
//                          110 SMULL, 111 SMLAL, 01x treated as MUL
//             SrcAE      - multiplicand (Rm)
//             SrcBE      - multiplier (Rs)
//             AccHiE     - RdHi accumulate operand (long accumulate)
//             AccLoE     - RdLo/Rn accumulate operand
//             MultBusyE  - stall request (combinational)
//             MultDoneE  - one-cycle result-valid pulse
//             ProdHiE    - upper result word (0 for 32-bit ops)
//             ProdLoE    - lower result word
//             MultFlagsE - {N,Z,C,V}; C and V are always 0
//  Macro    : MULT_EARLY_TERM_EN - leave CALC as soon as the remaining
//             multiplier bytes are all zero (3-6 cycle latency).
//  Revision : 1.0 - initial release
// ============================================================================
module mult_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        StartE,
    input  logic        FlushE,
    input  logic [2:0]  MultOpE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic [31:0] AccHiE,
    input  logic [31:0] AccLoE,
    output logic        MultBusyE,
    output logic        MultDoneE,
    output logic [31:0] ProdHiE,
    output logic [31:0] ProdLoE,
    output logic [3:0]  MultFlagsE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mag_a_q, mag_a_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [2:0]  op_q, op_d;
    logic        neg_q, neg_d;
    logic [63:0] acc_q, acc_d;
    logic [1:0]  iter_q, iter_d;
    logic [31:0] prod_hi_q, prod_hi_d;
    logic [31:0] prod_lo_q, prod_lo_d;
    logic [3:0]  flags_q, flags_d;

    // ------------------------------------------------------------------
    // Start acceptance and operand magnitudes
    // ------------------------------------------------------------------
    logic        w_accept;
    logic        w_signed_op;
    logic [31:0] w_src_a_mag;
    logic [31:0] w_src_b_mag;

    assign w_accept    = StartE & ~FlushE & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign w_signed_op = (MultOpE[2:1] == 2'b11);
    // Magnitudes are only taken for signed long ops; for everything else the
    // raw bits are already the unsigned operand. |-2^31| fits in 32 bits.
    assign w_src_a_mag = (w_signed_op & SrcAE[31]) ? (~SrcAE + 32'd1) : SrcAE;
    assign w_src_b_mag = (w_signed_op & SrcBE[31]) ? (~SrcBE + 32'd1) : SrcBE;

    // ------------------------------------------------------------------
    // One CALC iteration: magA x one multiplier byte, shifted into place
    // ------------------------------------------------------------------
    logic [7:0]  w_b_byte;
    logic [39:0] w_partial;
    logic [63:0] w_shifted;
    logic        w_rest_zero;
    logic        w_calc_last;

    assign w_b_byte  = mag_b_q[{iter_q, 3'b000} +: 8];
    assign w_partial = {8'd0, mag_a_q} * {32'd0, w_b_byte};
    assign w_shifted = {24'd0, w_partial} << {iter_q, 3'b000};

    // True when every multiplier byte above the current one is zero
    always_comb begin
        w_rest_zero = 1'b1;
        case (iter_q)
            2'd0:    w_rest_zero = (mag_b_q[31:8]  == 24'd0);
            2'd1:    w_rest_zero = (mag_b_q[31:16] == 16'd0);
            2'd2:    w_rest_zero = (mag_b_q[31:24] == 8'd0);
            default: w_rest_zero = 1'b1;
        endcase
    end

`ifdef MULT_EARLY_TERM_EN
    assign w_calc_last = (iter_q == 2'd3) | w_rest_zero;
`else
    assign w_calc_last = (iter_q == 2'd3);
`endif

    // ------------------------------------------------------------------
    // FIX: sign correction, accumulate, result formatting and flags
    // ------------------------------------------------------------------
    logic        w_long_op;
    logic        w_mla_op;
    logic        w_long_acc_op;
    logic [63:0] w_signed_res;
    logic [63:0] w_fix_long;
    logic [31:0] w_fix_short;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;
    logic        w_fix_n;
    logic        w_fix_z;

    assign w_long_op     = op_q[2];
    assign w_mla_op      = (op_q == 3'b001);
    assign w_long_acc_op = op_q[2] & op_q[0];
    assign w_signed_res  = neg_q ? (~acc_q + 64'd1) : acc_q;
    assign w_fix_long    = w_signed_res + (w_long_acc_op ? {acc_hi_q, acc_lo_q} : 64'd0);
    assign w_fix_short   = w_signed_res[31:0] + (w_mla_op ? acc_lo_q : 32'd0);
    assign w_fix_hi      = w_long_op ? w_fix_long[63:32] : 32'd0;
    assign w_fix_lo      = w_long_op ? w_fix_long[31:0]  : w_fix_short;
    assign w_fix_n       = w_long_op ? w_fix_long[63]    : w_fix_short[31];
    assign w_fix_z       = w_long_op ? (w_fix_long == 64'd0) : (w_fix_short == 32'd0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        op_d      = op_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        iter_d    = iter_q;
        prod_hi_d = prod_hi_q;
        prod_lo_d = prod_lo_q;
        flags_d   = flags_q;

        case (state_q)
            S_CALC: begin
                if (FlushE) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d  = acc_q + w_shifted;
                    iter_d = iter_q + 2'd1;
                    if (w_calc_last) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (FlushE) begin
                    state_d = S_IDLE;
                end else begin
                    prod_hi_d = w_fix_hi;
                    prod_lo_d = w_fix_lo;
                    flags_d   = {w_fix_n, w_fix_z, 2'b00};
                    state_d   = S_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a new operation
                if (w_accept) begin
                    mag_a_d  = w_src_a_mag;
                    mag_b_d  = w_src_b_mag;
                    acc_hi_d = AccHiE;
                    acc_lo_d = AccLoE;
                    op_d     = MultOpE;
                    neg_d    = w_signed_op & (SrcAE[31] ^ SrcBE[31]);
                    acc_d    = 64'd0;
                    iter_d   = 2'd0;
                    state_d  = S_CALC;
                end else begin
                    state_d  = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            mag_a_q   <= 32'd0;
            mag_b_q   <= 32'd0;
            acc_hi_q  <= 32'd0;
            acc_lo_q  <= 32'd0;
            op_q      <= 3'd0;
            neg_q     <= 1'b0;
            acc_q     <= 64'd0;
            iter_q    <= 2'd0;
            prod_hi_q <= 32'd0;
            prod_lo_q <= 32'd0;
            flags_q   <= 4'd0;
        end else begin
            state_q   <= state_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            iter_q    <= iter_d;
            prod_hi_q <= prod_hi_d;
            prod_lo_q <= prod_lo_d;
            flags_q   <= flags_d;
        end
    end

    // Busy is combinational so the stall is raised in the start cycle itself
    assign MultBusyE  = w_accept | (state_q == S_CALC) | (state_q == S_FIX);
    assign MultDoneE  = (state_q == S_DONE);
    assign ProdHiE    = prod_hi_q;
    assign ProdLoE    = prod_lo_q;
    assign MultFlagsE = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_unit
//  Purpose  : Directed self-checking bench for mult_unit. Cycle 0 is the
//             cycle in which StartE is presented; latency is the cycle index
//             in which MultDoneE is observed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_unit;

`ifdef MULT_EARLY_TERM_EN
    localparam int C_LAT_SMALL = 3;
    localparam int C_LAT_64K   = 5;
`else
    localparam int C_LAT_SMALL = 6;
    localparam int C_LAT_64K   = 6;
`endif
    localparam int C_LAT_FULL = 6;

    logic        clk;
    logic        reset;
    logic        StartE;
    logic        FlushE;
    logic [2:0]  MultOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [31:0] AccHiE;
    logic [31:0] AccLoE;
    logic        MultBusyE;
    logic        MultDoneE;
    logic [31:0] ProdHiE;
    logic [31:0] ProdLoE;
    logic [3:0]  MultFlagsE;

    int n_cmp = 0;
    int n_err = 0;

    mult_unit dut (
        .clk        (clk),
        .reset      (reset),
        .StartE     (StartE),
        .FlushE     (FlushE),
        .MultOpE    (MultOpE),
        .SrcAE      (SrcAE),
        .SrcBE      (SrcBE),
        .AccHiE     (AccHiE),
        .AccLoE     (AccLoE),
        .MultBusyE  (MultBusyE),
        .MultDoneE  (MultDoneE),
        .ProdHiE    (ProdHiE),
        .ProdLoE    (ProdLoE),
        .MultFlagsE (MultFlagsE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one operation in cycle 0, then waits (bounded) for DONE.
    // Returns the DONE cycle index (-1 on timeout) and a count of cycles in
    // which busy disagreed with its required value.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo,
                          output int lat, output int busy_bad);
        lat = -1;
        busy_bad = 0;
        @(negedge clk);
        MultOpE = op; SrcAE = a; SrcBE = b; AccHiE = hi; AccLoE = lo;
        StartE = 1'b1;
        #1;
        if (MultBusyE !== 1'b1) busy_bad++;
        @(posedge clk);
        #1 StartE = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (MultDoneE === 1'b1) begin
                lat = k;
                if (MultBusyE !== 1'b0) busy_bad++;
                break;
            end else if (MultBusyE !== 1'b1) begin
                busy_bad++;
            end
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({MultBusyE, MultDoneE, ProdHiE, ProdLoE, MultFlagsE} !== 70'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b hi=%h lo=%h flags=%b, want all 0",
                     MultBusyE, MultDoneE, ProdHiE, ProdLoE, MultFlagsE);
        end
    endtask

    task automatic test_mul();
        int lat, bb;
        run_op(3'b000, 32'd7, 32'd6, 32'd0, 32'd0, lat, bb);
        n_cmp++;
        if (lat !== C_LAT_SMALL) begin n_err++; $display("FAIL mul_latency: got %0d want %0d", lat, C_LAT_SMALL); end
        n_cmp++;
        if (bb !== 0) begin n_err++; $display("FAIL mul_busy: %0d bad cycles, want 0", bb); end
        n_cmp++;
        if ({ProdHiE, ProdLoE, MultFlagsE} !== {32'h0, 32'h0000002A, 4'b0000}) begin
            n_err++;
            $display("FAIL mul_result: got %h_%h flags=%b want 00000000_0000002a flags=0000", ProdHiE, ProdLoE, MultFlagsE);
        end
    endtask

    task automatic test_smull();
        int lat, bb;
        run_op(3'b110, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, lat, bb);
        n_cmp++;
        if ({ProdHiE, ProdLoE, MultFlagsE} !== {32'hFFFFFFFF, 32'hFFFFFFFA, 4'b1000}) begin
            n_err++;
            $display("FAIL smull_result: got %h_%h flags=%b want ffffffff_fffffffa flags=1000", ProdHiE, ProdLoE, MultFlagsE);
        end
    endtask

    task automatic test_umlal();
        int lat, bb;
        run_op(3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, lat, bb);
        n_cmp++;
        if (lat !== C_LAT_FULL || bb !== 0) begin
            n_err++; $display("FAIL umlal_timing: got lat=%0d busy_bad=%0d want lat=%0d busy_bad=0", lat, bb, C_LAT_FULL);
        end
        n_cmp++;
        if ({ProdHiE, ProdLoE, MultFlagsE} !== {32'hFFFFFFFE, 32'h00000002, 4'b1000}) begin
            n_err++;
            $display("FAIL umlal_result: got %h_%h flags=%b want fffffffe_00000002 flags=1000", ProdHiE, ProdLoE, MultFlagsE);
        end
    endtask

    task automatic test_mul_zero();
        int lat, bb;
        run_op(3'b000, 32'h00010000, 32'h00010000, 32'd0, 32'd0, lat, bb);
        n_cmp++;
        if (lat !== C_LAT_64K) begin n_err++; $display("FAIL mulz_latency: got %0d want %0d", lat, C_LAT_64K); end
        n_cmp++;
        if ({ProdHiE, ProdLoE, MultFlagsE} !== {32'h0, 32'h0, 4'b0100}) begin
            n_err++;
            $display("FAIL mulz_result: got %h_%h flags=%b want 00000000_00000000 flags=0100", ProdHiE, ProdLoE, MultFlagsE);
        end
    endtask

    task automatic test_mla();
        int lat, bb;
        run_op(3'b001, 32'd3, 32'd4, 32'hDEADBEEF, 32'd5, lat, bb);
        n_cmp++;
        if ({ProdHiE, ProdLoE, MultFlagsE} !== {32'h0, 32'h00000011, 4'b0000}) begin
            n_err++;
            $display("FAIL mla_result: got %h_%h flags=%b want 00000000_00000011 flags=0000", ProdHiE, ProdLoE, MultFlagsE);
        end
    endtask

    task automatic test_signed_edges();
        int lat, bb;
        // (-2^31) * (-2^31) = 2^62
        run_op(3'b110, 32'h80000000, 32'h80000000, 32'd0, 32'd0, lat, bb);
        n_cmp++;
        if ({ProdHiE, ProdLoE, MultFlagsE} !== {32'h40000000, 32'h0, 4'b0000}) begin
            n_err++;
            $display("FAIL smull_min: got %h_%h flags=%b want 40000000_00000000 flags=0000", ProdHiE, ProdLoE, MultFlagsE);
        end
        // (-3) * (-4) + 5 = 17
        run_op(3'b111, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'd0, 32'd5, lat, bb);
        n_cmp++;
        if ({ProdHiE, ProdLoE, MultFlagsE} !== {32'h0, 32'h00000011, 4'b0000}) begin
            n_err++;
            $display("FAIL smlal_negneg: got %h_%h flags=%b want 00000000_00000011 flags=0000", ProdHiE, ProdLoE, MultFlagsE);
        end
        // Reserved op 010 behaves as MUL: 0xFFFFFFFF * 2 truncated to 32 bits
        run_op(3'b010, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd9, lat, bb);
        n_cmp++;
        if ({ProdHiE, ProdLoE, MultFlagsE} !== {32'h0, 32'hFFFFFFFE, 4'b1000}) begin
            n_err++;
            $display("FAIL reserved_op: got %h_%h flags=%b want 00000000_fffffffe flags=1000", ProdHiE, ProdLoE, MultFlagsE);
        end
    endtask

    task automatic test_early_term();
        int lat, bb;
        run_op(3'b000, 32'd5, 32'd3, 32'd0, 32'd0, lat, bb);
        n_cmp++;
        if (lat !== C_LAT_SMALL || bb !== 0) begin
            n_err++; $display("FAIL early_term_timing: got lat=%0d busy_bad=%0d want lat=%0d busy_bad=0", lat, bb, C_LAT_SMALL);
        end
        n_cmp++;
        if (ProdLoE !== 32'h0000000F) begin n_err++; $display("FAIL early_term_result: got %h want 0000000f", ProdLoE); end
    endtask

    task automatic test_back_to_back();
        int lat, bb;
        int lat2;
        run_op(3'b100, 32'd2, 32'h01000000, 32'd0, 32'd0, lat, bb);
        n_cmp++;
        if (lat !== C_LAT_FULL || ProdLoE !== 32'h02000000 || ProdHiE !== 32'h0) begin
            n_err++; $display("FAIL b2b_first: got lat=%0d %h_%h want lat=%0d 00000000_02000000", lat, ProdHiE, ProdLoE, C_LAT_FULL);
        end
        // Second start is presented in the DONE cycle of the first
        MultOpE = 3'b000; SrcAE = 32'd3; SrcBE = 32'h01000001; AccHiE = 32'd0; AccLoE = 32'd0;
        StartE = 1'b1;
        #1;
        n_cmp++;
        if (MultBusyE !== 1'b1 || MultDoneE !== 1'b1) begin
            n_err++; $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=1", MultBusyE, MultDoneE);
        end
        @(posedge clk);
        #1 StartE = 1'b0;
        lat2 = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (MultDoneE === 1'b1) begin lat2 = k; break; end
        end
        n_cmp++;
        if (lat2 !== C_LAT_FULL || ProdLoE !== 32'h03000003) begin
            n_err++; $display("FAIL b2b_second: got lat=%0d lo=%h want lat=%0d lo=03000003", lat2, ProdLoE, C_LAT_FULL);
        end
    endtask

    task automatic test_flush_start();
        int bad;
        bad = 0;
        @(negedge clk);
        MultOpE = 3'b000; SrcAE = 32'd9; SrcBE = 32'd9;
        StartE = 1'b1; FlushE = 1'b1;
        #1;
        if (MultBusyE !== 1'b0) bad++;
        @(posedge clk);
        #1 StartE = 1'b0; FlushE = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (MultBusyE !== 1'b0 || MultDoneE !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0 || ProdLoE !== 32'h03000003) begin
            n_err++; $display("FAIL flush_start: got %0d busy/done violations lo=%h want 0 violations lo=03000003", bad, ProdLoE);
        end
    endtask

    task automatic test_flush_mid();
        int bad;
        bad = 0;
        @(negedge clk);
        MultOpE = 3'b000; SrcAE = 32'h1234; SrcBE = 32'h01000000;
        StartE = 1'b1;
        @(posedge clk);             // edge 0
        #1 StartE = 1'b0;           // cycle 1
        @(posedge clk);             // cycle 2
        @(posedge clk);
        #1 FlushE = 1'b1;           // cycle 3
        @(posedge clk);
        #1 FlushE = 1'b0;           // cycle 4
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (MultBusyE !== 1'b0 || MultDoneE !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL flush_mid_idle: got %0d busy/done violations want 0", bad); end
        n_cmp++;
        if ({ProdHiE, ProdLoE, MultFlagsE} !== {32'h0, 32'h03000003, 4'b0000}) begin
            n_err++;
            $display("FAIL flush_mid_hold: got %h_%h flags=%b want 00000000_03000003 flags=0000", ProdHiE, ProdLoE, MultFlagsE);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        int lat, bb;
        bad = 0;
        @(negedge clk);
        MultOpE = 3'b000; SrcAE = 32'h1234; SrcBE = 32'h01000000;
        StartE = 1'b1;
        @(posedge clk);
        #1 StartE = 1'b0;           // cycle 1
        @(posedge clk);
        #1 reset = 1'b0;            // cycle 2
        #1;
        n_cmp++;
        if ({MultBusyE, MultDoneE, ProdHiE, ProdLoE, MultFlagsE} !== 70'd0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b hi=%h lo=%h flags=%b want all 0",
                     MultBusyE, MultDoneE, ProdHiE, ProdLoE, MultFlagsE);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (MultBusyE !== 1'b0 || MultDoneE !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL reset_mid_idle: got %0d busy/done violations want 0", bad); end
        run_op(3'b000, 32'd7, 32'd6, 32'd0, 32'd0, lat, bb);
        n_cmp++;
        if (lat !== C_LAT_SMALL || ProdLoE !== 32'h0000002A) begin
            n_err++; $display("FAIL after_reset_op: got lat=%0d lo=%h want lat=%0d lo=0000002a", lat, ProdLoE, C_LAT_SMALL);
        end
    endtask

    initial begin
        reset   = 1'b0;
        StartE  = 1'b0;
        FlushE  = 1'b0;
        MultOpE = 3'd0;
        SrcAE   = 32'd0;
        SrcBE   = 32'd0;
        AccHiE  = 32'd0;
        AccLoE  = 32'd0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        test_mul();
        test_smull();
        test_umlal();
        test_mul_zero();
        test_mla();
        test_signed_edges();
        test_early_term();
        test_back_to_back();
        test_flush_start();
        test_flush_mid();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
